// File: rtl/cpu_pkg.sv
// Shared control-path definitions: handler state encoding, cause codes and default vectors.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_USER   = 2'd0,
        ST_KERNEL = 2'd1,
        ST_GUARD  = 2'd2
    } ctrl_state_e;

    localparam logic [7:0]  CAUSE_EXC      = 8'h80;
    localparam logic [7:0]  CAUSE_IRQ_BASE = 8'h00;
    localparam logic [31:0] VEC_IRQ_DFLT   = 32'h8000_0004;
    localparam logic [31:0] VEC_EXC_DFLT   = 32'h8000_0008;

    // Channel index is zero-extended into the 8-bit cause field.
    function automatic logic [7:0] irq_cause(input logic [3:0] idx);
        return CAUSE_IRQ_BASE + {4'h0, idx};
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over N request lines.
module irq_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [3:0]   idx
);

    // Scan from the top down so the lowest set bit is the last to write idx.
    always_comb begin
        valid = |req;
        idx   = 4'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
    end

endmodule

// File: rtl/irq_exc_ctrl.sv
// Interrupt/exception controller: pending latches, mask, arbitration, same-cycle redirect,
// kernel/user tracking with an eret guard cycle.
module irq_exc_ctrl
    import cpu_pkg::*;
#(
    parameter int                 N_IRQ     = 4,
    parameter int                 ADDR_W    = 32,
    parameter logic [N_IRQ-1:0]   EDGE_TRIG = {N_IRQ{1'b1}},
    parameter logic [N_IRQ-1:0]   MASK_RST  = {N_IRQ{1'b1}},
    parameter logic [ADDR_W-1:0]  VEC_IRQ   = VEC_IRQ_DFLT,
    parameter logic [ADDR_W-1:0]  VEC_EXC   = VEC_EXC_DFLT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_IRQ-1:0]  irq_in,
    input  logic              exc_req,
    input  logic              eret,
    input  logic              instr_valid,
    input  logic [ADDR_W-1:0] pc_cur,
    input  logic              mask_we,
    input  logic [N_IRQ-1:0]  mask_wdata,
    output logic              take,
    output logic [ADDR_W-1:0] take_vec,
    output logic [ADDR_W-1:0] epc,
    output logic [7:0]        cause,
    output logic              kernel_mode,
    output logic              double_fault,
    output logic [N_IRQ-1:0]  pending
);

    ctrl_state_e       state_r;
    logic [N_IRQ-1:0]  sample_r;
    logic [N_IRQ-1:0]  edge_r;
    logic [N_IRQ-1:0]  mask_r;
    logic [ADDR_W-1:0] epc_r;
    logic [7:0]        cause_r;
    logic              kernel_r;
    logic              dfault_r;

    logic              irq_valid_s;
    logic [3:0]        irq_idx_s;
    logic              exc_take_s;
    logic              irq_take_s;
    logic [N_IRQ-1:0]  edge_set_s;
    logic [N_IRQ-1:0]  edge_clr_s;
    logic [7:0]        code_s;

    assign pending = (EDGE_TRIG & edge_r) | (~EDGE_TRIG & irq_in);

    irq_prio_enc #(.N(N_IRQ)) u_prio (
        .req   (pending & mask_r),
        .valid (irq_valid_s),
        .idx   (irq_idx_s)
    );

    // Arbitration: exceptions in any state, interrupts only in USER; reset forces no redirect.
    always_comb begin
        exc_take_s = reset & instr_valid & exc_req;
        irq_take_s = reset & instr_valid & ~exc_req & (state_r == ST_USER) & irq_valid_s;
        take       = exc_take_s | irq_take_s;
        edge_set_s = EDGE_TRIG & irq_in & ~sample_r;
        if (irq_take_s) begin
            edge_clr_s = N_IRQ'(1) << irq_idx_s;
        end else begin
            edge_clr_s = {N_IRQ{1'b0}};
        end
        if (exc_take_s) begin
            take_vec = VEC_EXC;
            code_s   = CAUSE_EXC;
        end else if (irq_take_s) begin
            take_vec = VEC_IRQ;
            code_s   = irq_cause(irq_idx_s);
        end else begin
            take_vec = {ADDR_W{1'b0}};
            code_s   = 8'h00;
        end
    end

    // Pending latches and mask; a new edge survives a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_r <= {N_IRQ{1'b0}};
            edge_r   <= {N_IRQ{1'b0}};
            mask_r   <= MASK_RST;
        end else begin
            sample_r <= irq_in;
            edge_r   <= (edge_r & ~edge_clr_s) | edge_set_s;
            if (mask_we) begin
                mask_r <= mask_wdata;
            end else begin
                mask_r <= mask_r;
            end
        end
    end

    // Handler state machine with registered epc/cause/mode flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_USER;
            epc_r    <= {ADDR_W{1'b0}};
            cause_r  <= 8'h00;
            kernel_r <= 1'b0;
            dfault_r <= 1'b0;
        end else if (take) begin
            if (state_r == ST_KERNEL) begin
                dfault_r <= 1'b1;
            end else begin
                epc_r    <= pc_cur;
                cause_r  <= code_s;
                state_r  <= ST_KERNEL;
                kernel_r <= 1'b1;
            end
        end else if (instr_valid) begin
            case (state_r)
                ST_KERNEL: begin
                    if (eret) begin
                        state_r  <= ST_GUARD;
                        kernel_r <= 1'b0;
                    end else begin
                        state_r  <= ST_KERNEL;
                    end
                end
                ST_GUARD: state_r <= ST_USER;
                ST_USER:  state_r <= ST_USER;
                default: begin
                    state_r  <= ST_USER;
                    kernel_r <= 1'b0;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    assign epc          = epc_r;
    assign cause        = cause_r;
    assign kernel_mode  = kernel_r;
    assign double_fault = dfault_r;

endmodule

// File: tb/tb_irq_exc_ctrl.sv
// Directed bench for irq_exc_ctrl: an edge-triggered instance and a level-mode instance.
module tb_irq_exc_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  irq = 4'h0;
    logic        exc = 1'b0;
    logic        er = 1'b0;
    logic        iv = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        mwe = 1'b0;
    logic [3:0]  mwd = 4'h0;
    logic        take;
    logic [31:0] take_vec;
    logic [31:0] epc;
    logic [7:0]  cause;
    logic        kmode;
    logic        dfault;
    logic [3:0]  pend;

    logic [3:0]  irq_l = 4'h0;
    logic        iv_l = 1'b0;
    logic        mwe_l = 1'b0;
    logic [3:0]  mwd_l = 4'h0;
    logic        take_l;
    logic [31:0] take_vec_l;
    logic [31:0] epc_l;
    logic [7:0]  cause_l;
    logic        kmode_l;
    logic        dfault_l;
    logic [3:0]  pend_l;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    irq_exc_ctrl #(.N_IRQ(4), .ADDR_W(32), .EDGE_TRIG(4'hF), .MASK_RST(4'hF)) dut (
        .clk(clk), .reset(reset), .irq_in(irq), .exc_req(exc), .eret(er),
        .instr_valid(iv), .pc_cur(pc), .mask_we(mwe), .mask_wdata(mwd),
        .take(take), .take_vec(take_vec), .epc(epc), .cause(cause),
        .kernel_mode(kmode), .double_fault(dfault), .pending(pend)
    );

    irq_exc_ctrl #(.N_IRQ(4), .ADDR_W(32), .EDGE_TRIG(4'h0), .MASK_RST(4'b1110)) dut_l (
        .clk(clk), .reset(reset), .irq_in(irq_l), .exc_req(1'b0), .eret(1'b0),
        .instr_valid(iv_l), .pc_cur(32'h0040_0100), .mask_we(mwe_l), .mask_wdata(mwd_l),
        .take(take_l), .take_vec(take_vec_l), .epc(epc_l), .cause(cause_l),
        .kernel_mode(kmode_l), .double_fault(dfault_l), .pending(pend_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state, with a request present that reset must suppress
        iv = 1'b1; exc = 1'b1;
        #12;
        chk("rst_take", 32'(take), 32'd0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_cause", 32'(cause), 32'h0);
        chk("rst_kmode", 32'(kmode), 32'd0);
        chk("rst_dfault", 32'(dfault), 32'd0);
        chk("rst_pend", 32'(pend), 32'h0);
        exc = 1'b0; iv = 1'b0;
        #3 reset = 1'b1;
        tick();

        // 1: edge irq 2
        iv = 1'b1; irq = 4'b0100; pc = 32'h0040_0010;
        #1 chk("t1_take_pre", 32'(take), 32'd0);
        tick();
        irq = 4'h0;
        chk("t1_pend", 32'(pend), 32'h4);
        chk("t1_take", 32'(take), 32'd1);
        chk("t1_vec", take_vec, 32'h8000_0004);
        tick();
        chk("t1_epc", epc, 32'h0040_0010);
        chk("t1_cause", 32'(cause), 32'h02);
        chk("t1_kmode", 32'(kmode), 32'd1);
        chk("t1_pend_clr", 32'(pend), 32'h0);
        er = 1'b1; tick(); er = 1'b0;
        chk("t1_eret_kmode", 32'(kmode), 32'd0);
        tick();

        // 2: exception beats interrupts
        irq = 4'b1010; tick(); irq = 4'h0;
        exc = 1'b1; pc = 32'h0040_0020;
        #1 chk("t2_take", 32'(take), 32'd1);
        chk("t2_vec", take_vec, 32'h8000_0008);
        tick(); exc = 1'b0;
        chk("t2_cause", 32'(cause), 32'h80);
        chk("t2_epc", epc, 32'h0040_0020);
        chk("t2_pend", 32'(pend), 32'ha);
        er = 1'b1; tick(); er = 1'b0;
        chk("t2_guard_take", 32'(take), 32'd0);
        tick();
        chk("t2_irq_take", 32'(take), 32'd1);
        chk("t2_irq_vec", take_vec, 32'h8000_0004);
        tick();
        chk("t2_irq_cause", 32'(cause), 32'h01);
        chk("t2_pend_after", 32'(pend), 32'h8);

        // 4: nesting blocked in kernel, guard cycle after eret
        irq = 4'b0010;
        #1 chk("t4_kern_take0", 32'(take), 32'd0);
        tick(); irq = 4'h0;
        chk("t4_pend", 32'(pend), 32'ha);
        chk("t4_kern_take1", 32'(take), 32'd0);
        er = 1'b1; tick(); er = 1'b0;
        chk("t4_guard_take", 32'(take), 32'd0);
        chk("t4_guard_kmode", 32'(kmode), 32'd0);
        pc = 32'h0040_0030;
        tick();
        chk("t4_take", 32'(take), 32'd1);
        tick();
        chk("t4_cause", 32'(cause), 32'h01);
        chk("t4_epc", epc, 32'h0040_0030);

        // 5: double fault keeps epc/cause
        exc = 1'b1; pc = 32'h0040_0040;
        #1 chk("t5_take", 32'(take), 32'd1);
        chk("t5_vec", take_vec, 32'h8000_0008);
        tick(); exc = 1'b0;
        chk("t5_dfault", 32'(dfault), 32'd1);
        chk("t5_epc", epc, 32'h0040_0030);
        chk("t5_cause", 32'(cause), 32'h01);
        chk("t5_kmode", 32'(kmode), 32'd1);

        // 6: stall holds pending, then reset from kernel restores mask
        er = 1'b1; tick(); er = 1'b0;
        tick();
        iv = 1'b0;
        #1 chk("t6_stall_take0", 32'(take), 32'd0);
        tick();
        chk("t6_stall_take1", 32'(take), 32'd0);
        chk("t6_stall_pend", 32'(pend), 32'h8);
        iv = 1'b1; mwe = 1'b1; mwd = 4'h0;
        #1 chk("t6_take3", 32'(take), 32'd1);
        tick(); mwe = 1'b0;
        chk("t6_cause3", 32'(cause), 32'h03);
        chk("t6_kmode", 32'(kmode), 32'd1);
        #2 reset = 1'b0;
        #1 chk("t6_rst_take", 32'(take), 32'd0);
        chk("t6_rst_epc", epc, 32'h0);
        chk("t6_rst_cause", 32'(cause), 32'h0);
        chk("t6_rst_kmode", 32'(kmode), 32'd0);
        chk("t6_rst_dfault", 32'(dfault), 32'd0);
        chk("t6_rst_pend", 32'(pend), 32'h0);
        #1 reset = 1'b1;
        tick();
        irq = 4'b0001; tick(); irq = 4'h0;
        chk("t6_mask_rst_take", 32'(take), 32'd1);
        chk("t6_mask_rst_vec", take_vec, 32'h8000_0004);
        iv = 1'b0;

        // 3: level mode with mask write
        irq_l = 4'b0001; iv_l = 1'b1;
        #1 chk("t3_pend", 32'(pend_l), 32'h1);
        chk("t3_masked0", 32'(take_l), 32'd0);
        tick();
        chk("t3_masked1", 32'(take_l), 32'd0);
        mwe_l = 1'b1; mwd_l = 4'hF;
        #1 chk("t3_write_cycle", 32'(take_l), 32'd0);
        tick(); mwe_l = 1'b0;
        chk("t3_take", 32'(take_l), 32'd1);
        chk("t3_vec", take_vec_l, 32'h8000_0004);
        tick();
        chk("t3_cause", 32'(cause_l), 32'h00);
        chk("t3_level_pend", 32'(pend_l), 32'h1);
        iv_l = 1'b0; irq_l = 4'h0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
